// File: rtl/contador_hora_alarma_if.sv
// Control inputs and BCD clock/alarm outputs of the time-of-day counter.
// The counter connects through the slave modport; its driver uses the master modport.
interface contador_hora_alarma_if;
    logic       tick_in;
    logic [1:0] modo;
    logic       inc_min;
    logic       inc_hr;
    logic       alarma_en;
    logic       apagar;

    logic [1:0] hr_d;
    logic [3:0] hr_u;
    logic [2:0] min_d;
    logic [3:0] min_u;
    logic [1:0] al_hr_d;
    logic [3:0] al_hr_u;
    logic [2:0] al_min_d;
    logic [3:0] al_min_u;
    logic       sonando;

    modport master (
        output tick_in, modo, inc_min, inc_hr, alarma_en, apagar,
        input  hr_d, hr_u, min_d, min_u,
        input  al_hr_d, al_hr_u, al_min_d, al_min_u,
        input  sonando
    );

    modport slave (
        input  tick_in, modo, inc_min, inc_hr, alarma_en, apagar,
        output hr_d, hr_u, min_d, min_u,
        output al_hr_d, al_hr_u, al_min_d, al_min_u,
        output sonando
    );
endinterface

// File: rtl/contador_hora_alarma.sv
// BCD time of day (00:00-23:59) advanced by the 1-minute divider, with a settable alarm.
// The alarm rings through a small IDLE/RING/DONE state machine.
module contador_hora_alarma #(
    parameter int unsigned ALARM_DUR_MIN = 1,
    parameter int unsigned AL_RST_HR     = 6
) (
    input logic                   reloje,
    input logic                   rst_n,
    contador_hora_alarma_if.slave bus
);

    localparam int unsigned HR_W   = 6;
    localparam int unsigned MIN_W  = 7;
    localparam int unsigned RING_W = 6;

    localparam logic [1:0]        AL_RST_D   = 2'(AL_RST_HR / 10);
    localparam logic [3:0]        AL_RST_U   = 4'(AL_RST_HR % 10);
    localparam logic [RING_W-1:0] RING_LIMIT = RING_W'(ALARM_DUR_MIN);
    localparam logic [MIN_W-1:0]  MIN_LAST   = {3'd5, 4'd9};
    localparam logic [HR_W-1:0]   HR_LAST    = {2'd2, 4'd3};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RING = 2'd1,
        DONE = 2'd2
    } state_t;

    // Minutes are {tens[2:0], units[3:0]}; 59 wraps to 00.
    function automatic logic [MIN_W-1:0] min_next(input logic [MIN_W-1:0] m);
        logic [MIN_W-1:0] r;
        r = m;
        if (m[3:0] == 4'd9) begin
            r[3:0] = 4'd0;
            r[6:4] = (m[6:4] == 3'd5) ? 3'd0 : m[6:4] + 3'd1;
        end else begin
            r[3:0] = m[3:0] + 4'd1;
        end
        return r;
    endfunction

    // Hours are {tens[1:0], units[3:0]}; 23 wraps to 00.
    function automatic logic [HR_W-1:0] hr_next(input logic [HR_W-1:0] h);
        logic [HR_W-1:0] r;
        r = h;
        if (h == HR_LAST) begin
            r = '0;
        end else if (h[3:0] == 4'd9) begin
            r[3:0] = 4'd0;
            r[5:4] = h[5:4] + 2'd1;
        end else begin
            r[3:0] = h[3:0] + 4'd1;
        end
        return r;
    endfunction

    logic [2:0] tick_sync;
    logic [2:0] min_sync;
    logic [2:0] hr_sync;
    logic       tick;
    logic       min_p;
    logic       hr_p;
    logic       set_time;
    logic       set_alarm;

    logic [HR_W-1:0]  hr_q, hr_n;
    logic [MIN_W-1:0] min_q, min_n;
    logic [HR_W-1:0]  al_hr_q, al_hr_n;
    logic [MIN_W-1:0] al_min_q, al_min_n;
    logic             time_chg_q, time_chg_n;
    logic             match;

    state_t            state, state_n;
    logic [RING_W-1:0] ring_cnt, ring_cnt_n, ring_cnt_inc;
    logic              sonando_q, sonando_n;

    // Two-flop synchronisers plus one delay flop for rising-edge detection.
    always_ff @(posedge reloje) begin
        if (!rst_n) begin
            tick_sync <= '0;
            min_sync  <= '0;
            hr_sync   <= '0;
        end else begin
            tick_sync <= {tick_sync[1:0], bus.tick_in};
            min_sync  <= {min_sync[1:0],  bus.inc_min};
            hr_sync   <= {hr_sync[1:0],   bus.inc_hr};
        end
    end

    assign tick      = tick_sync[1] & ~tick_sync[2];
    assign min_p     = min_sync[1]  & ~min_sync[2];
    assign hr_p      = hr_sync[1]   & ~hr_sync[2];
    assign set_time  = (bus.modo == 2'b01);
    assign set_alarm = (bus.modo == 2'b10);

    always_comb begin
        hr_n       = hr_q;
        min_n      = min_q;
        al_hr_n    = al_hr_q;
        al_min_n   = al_min_q;
        time_chg_n = 1'b0;
        if (set_time) begin
            // Manual edits never carry between minutes and hours.
            if (min_p) min_n = min_next(min_q);
            if (hr_p)  hr_n  = hr_next(hr_q);
            time_chg_n = min_p | hr_p;
        end else if (tick) begin
            min_n = min_next(min_q);
            if (min_q == MIN_LAST) hr_n = hr_next(hr_q);
            time_chg_n = 1'b1;
        end
        if (set_alarm) begin
            if (min_p) al_min_n = min_next(al_min_q);
            if (hr_p)  al_hr_n  = hr_next(al_hr_q);
        end
    end

    always_ff @(posedge reloje) begin
        if (!rst_n) begin
            hr_q       <= '0;
            min_q      <= '0;
            al_hr_q    <= {AL_RST_D, AL_RST_U};
            al_min_q   <= '0;
            time_chg_q <= 1'b0;
        end else begin
            hr_q       <= hr_n;
            min_q      <= min_n;
            al_hr_q    <= al_hr_n;
            al_min_q   <= al_min_n;
            time_chg_q <= time_chg_n;
        end
    end

    assign match        = (hr_q == al_hr_q) && (min_q == al_min_q);
    assign ring_cnt_inc = ring_cnt + RING_W'(1);

    // Alarm state register; sonando and the ring counter are registered alongside it.
    always_ff @(posedge reloje) begin
        if (!rst_n) begin
            state     <= IDLE;
            ring_cnt  <= '0;
            sonando_q <= 1'b0;
        end else begin
            state     <= state_n;
            ring_cnt  <= ring_cnt_n;
            sonando_q <= sonando_n;
        end
    end

    // Only a fresh time change onto the alarm starts ringing, so a static match is ignored.
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (bus.alarma_en && !set_time && match && time_chg_q) state_n = RING;
            end
            RING: begin
                if (!bus.alarma_en || set_time)              state_n = IDLE;
                else if (bus.apagar)                         state_n = DONE;
                else if (tick && (ring_cnt_inc >= RING_LIMIT)) state_n = DONE;
            end
            DONE: begin
                if (!match) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        ring_cnt_n = ring_cnt;
        sonando_n  = (state_n == RING);
        if (state != RING) begin
            ring_cnt_n = '0;
        end else if (tick) begin
            ring_cnt_n = ring_cnt_inc;
        end
    end

    assign bus.hr_d     = hr_q[5:4];
    assign bus.hr_u     = hr_q[3:0];
    assign bus.min_d    = min_q[6:4];
    assign bus.min_u    = min_q[3:0];
    assign bus.al_hr_d  = al_hr_q[5:4];
    assign bus.al_hr_u  = al_hr_q[3:0];
    assign bus.al_min_d = al_min_q[6:4];
    assign bus.al_min_u = al_min_q[3:0];
    assign bus.sonando  = sonando_q;

endmodule

// File: tb/tb_contador_hora_alarma.sv
// Self-checking bench for contador_hora_alarma: vector table plus hand-written alarm sequences.
module tb_contador_hora_alarma;

    logic reloje = 1'b0;
    logic rst_n  = 1'b0;

    contador_hora_alarma_if bus ();

    contador_hora_alarma #(
        .ALARM_DUR_MIN(1),
        .AL_RST_HR    (6)
    ) dut (
        .reloje(reloje),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 reloje = ~reloje;

    typedef enum int {OP_TICK, OP_MIN, OP_HR, OP_BOTH} op_t;

    typedef struct {
        op_t        op;
        logic [1:0] modo;
        int         h;
        int         m;
        int         ah;
        int         am;
    } vec_t;

    typedef struct {
        string       name;
        logic [26:0] val;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[9];
    int   errors = 0;
    int   checks = 0;

    function automatic logic [12:0] bcd(input int h, input int m);
        return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10)};
    endfunction

    function automatic logic [26:0] snap();
        return {bus.hr_d, bus.hr_u, bus.min_d, bus.min_u,
                bus.al_hr_d, bus.al_hr_u, bus.al_min_d, bus.al_min_u, bus.sonando};
    endfunction

    function automatic string fmt(input logic [26:0] v);
        return $sformatf("%0d%0d:%0d%0d al=%0d%0d:%0d%0d son=%0b",
                         v[26:25], v[24:21], v[20:18], v[17:14],
                         v[13:12], v[11:8], v[7:5], v[4:1], v[0]);
    endfunction

    function automatic bit legal(input logic [1:0] hd, input logic [3:0] hu,
                                 input logic [2:0] md, input logic [3:0] mu);
        return (hd <= 2'd2) && (hu <= 4'd9) && (hd != 2'd2 || hu <= 4'd3) &&
               (md <= 3'd5) && (mu <= 4'd9);
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge reloje);
        #1;
    endtask

    task automatic expect_st(input string name, input int h, input int m,
                             input int ah, input int am, input logic son);
        exp_t e;
        e.name = name;
        e.val  = {bcd(h, m), bcd(ah, am), son};
        sb.push_back(e);
    endtask

    task automatic check_st();
        exp_t        e;
        logic [26:0] got;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got %s required a pending expectation", fmt(snap()));
        end else begin
            e   = sb.pop_front();
            got = snap();
            if (got !== e.val) begin
                errors++;
                $display("FAIL %s: got %s required %s", e.name, fmt(got), fmt(e.val));
            end
        end
    endtask

    task automatic chk(input string name, input int h, input int m,
                       input int ah, input int am, input logic son);
        expect_st(name, h, m, ah, am, son);
        check_st();
    endtask

    task automatic do_op(input op_t op);
        case (op)
            OP_TICK: bus.tick_in = 1'b1;
            OP_MIN:  bus.inc_min = 1'b1;
            OP_HR:   bus.inc_hr  = 1'b1;
            default: begin
                bus.inc_min = 1'b1;
                bus.inc_hr  = 1'b1;
            end
        endcase
        cyc(3);
        bus.tick_in = 1'b0;
        bus.inc_min = 1'b0;
        bus.inc_hr  = 1'b0;
        cyc(2);
    endtask

    // Digits must be legal BCD on every cycle outside reset.
    always @(negedge reloje) begin
        if (rst_n === 1'b1) begin
            checks++;
            if (!legal(bus.hr_d, bus.hr_u, bus.min_d, bus.min_u) ||
                !legal(bus.al_hr_d, bus.al_hr_u, bus.al_min_d, bus.al_min_u)) begin
                errors++;
                $display("FAIL bcd_legal: got %s required legal BCD digits", fmt(snap()));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{OP_MIN,  2'b00, 0, 0, 6, 0};
        tbl[1] = '{OP_HR,   2'b11, 0, 0, 6, 0};
        tbl[2] = '{OP_TICK, 2'b11, 0, 1, 6, 0};
        tbl[3] = '{OP_BOTH, 2'b01, 1, 2, 6, 0};
        tbl[4] = '{OP_TICK, 2'b01, 1, 2, 6, 0};
        tbl[5] = '{OP_HR,   2'b10, 1, 2, 7, 0};
        tbl[6] = '{OP_MIN,  2'b10, 1, 2, 7, 1};
        tbl[7] = '{OP_BOTH, 2'b10, 1, 2, 8, 2};
        tbl[8] = '{OP_TICK, 2'b10, 1, 3, 8, 2};

        bus.tick_in   = 1'b0;
        bus.modo      = 2'b00;
        bus.inc_min   = 1'b0;
        bus.inc_hr    = 1'b0;
        bus.alarma_en = 1'b0;
        bus.apagar    = 1'b0;
        cyc(2);
        chk("reset_state", 0, 0, 6, 0, 0);

        // First tick: update lands on the third sampling edge.
        rst_n       = 1'b1;
        bus.tick_in = 1'b1;
        cyc(2);
        chk("tick_latency_2", 0, 0, 6, 0, 0);
        cyc(1);
        chk("tick_latency_3", 0, 1, 6, 0, 0);
        bus.tick_in = 1'b0;
        cyc(2);
        for (int i = 1; i < 60; i++) begin
            do_op(OP_TICK);
            if (i == 9) chk("min_tens_carry", 0, 10, 6, 0, 0);
        end
        chk("sixty_ticks", 1, 0, 6, 0, 0);

        // Preload 23:59 and roll over midnight.
        rst_n = 1'b0;
        cyc(1);
        rst_n    = 1'b1;
        bus.modo = 2'b01;
        for (int i = 0; i < 23; i++) do_op(OP_HR);
        chk("preset_hr23", 23, 0, 6, 0, 0);
        for (int i = 0; i < 59; i++) do_op(OP_MIN);
        chk("preset_2359", 23, 59, 6, 0, 0);
        do_op(OP_TICK);
        chk("tick_in_set_frozen", 23, 59, 6, 0, 0);
        bus.modo = 2'b00;
        do_op(OP_TICK);
        chk("midnight_wrap", 0, 0, 6, 0, 0);

        for (int i = 0; i < 9; i++) begin
            bus.modo = tbl[i].modo;
            expect_st($sformatf("vec%0d", i), tbl[i].h, tbl[i].m, tbl[i].ah, tbl[i].am, 1'b0);
            do_op(tbl[i].op);
            check_st();
        end

        // Set-mode wraps: minutes without carry, hours 23 to 00.
        bus.modo = 2'b01;
        for (int i = 0; i < 56; i++) do_op(OP_MIN);
        chk("set_0159", 1, 59, 8, 2, 0);
        do_op(OP_MIN);
        chk("min_wrap_no_carry", 1, 0, 8, 2, 0);
        for (int i = 0; i < 22; i++) do_op(OP_HR);
        chk("set_hr23", 23, 0, 8, 2, 0);
        do_op(OP_HR);
        chk("hr_wrap", 0, 0, 8, 2, 0);

        // Alarm 06:00 reached from 05:59 and auto-stopped after one tick.
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) do_op(OP_HR);
        for (int i = 0; i < 59; i++) do_op(OP_MIN);
        chk("preset_0559", 5, 59, 6, 0, 0);
        bus.modo      = 2'b00;
        bus.alarma_en = 1'b1;
        cyc(2);
        bus.tick_in = 1'b1;
        cyc(3);
        chk("alarm_match_time", 6, 0, 6, 0, 0);
        cyc(1);
        chk("ring_rise", 6, 0, 6, 0, 1);
        bus.tick_in = 1'b0;
        cyc(2);
        chk("ring_hold", 6, 0, 6, 0, 1);
        bus.tick_in = 1'b1;
        cyc(3);
        chk("auto_stop", 6, 1, 6, 0, 0);
        bus.tick_in = 1'b0;
        cyc(5);
        chk("no_retrigger", 6, 1, 6, 0, 0);

        // Editing alarm onto the current time must stay silent.
        bus.modo = 2'b10;
        do_op(OP_MIN);
        chk("alarm_eq_time_no_ring", 6, 1, 6, 1, 0);
        cyc(5);
        chk("alarm_eq_time_quiet", 6, 1, 6, 1, 0);
        do_op(OP_MIN);
        bus.tick_in = 1'b1;
        cyc(3);
        chk("edit_mode_counts", 6, 2, 6, 2, 0);
        cyc(1);
        chk("ring_in_alarm_mode", 6, 2, 6, 2, 1);
        bus.tick_in = 1'b0;
        bus.apagar  = 1'b1;
        cyc(1);
        chk("apagar_stop", 6, 2, 6, 2, 0);
        bus.apagar = 1'b0;
        cyc(5);
        chk("done_holds", 6, 2, 6, 2, 0);

        // Disarm while ringing, then re-arm on a static match.
        do_op(OP_MIN);
        bus.tick_in = 1'b1;
        cyc(4);
        chk("ring_again", 6, 3, 6, 3, 1);
        bus.tick_in   = 1'b0;
        bus.alarma_en = 1'b0;
        cyc(1);
        chk("disarm_stop", 6, 3, 6, 3, 0);
        bus.alarma_en = 1'b1;
        cyc(5);
        chk("rearm_no_trigger", 6, 3, 6, 3, 0);

        // Reset in the middle of ringing.
        do_op(OP_MIN);
        bus.tick_in = 1'b1;
        cyc(4);
        chk("ring_pre_reset", 6, 4, 6, 4, 1);
        bus.tick_in = 1'b0;
        rst_n       = 1'b0;
        cyc(1);
        chk("reset_mid_ring", 0, 0, 6, 0, 0);
        rst_n = 1'b1;
        cyc(2);
        chk("post_reset_idle", 0, 0, 6, 0, 0);

        // apagar held across the trigger: one RING cycle, then DONE.
        for (int i = 0; i < 18; i++) do_op(OP_HR);
        do_op(OP_MIN);
        chk("alarm_0001", 0, 0, 0, 1, 0);
        bus.apagar  = 1'b1;
        bus.tick_in = 1'b1;
        cyc(3);
        chk("apagar_held_match", 0, 1, 0, 1, 0);
        cyc(1);
        chk("apagar_held_ring", 0, 1, 0, 1, 1);
        cyc(1);
        chk("apagar_held_done", 0, 1, 0, 1, 0);
        bus.tick_in = 1'b0;
        bus.apagar  = 1'b0;
        cyc(2);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d entries required 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/contador_hora_alarma.md
Name: contador_hora_alarma

Overview:
- Downstream consumer of the 1-minute divider output.
- Synchronises and edge-detects the divider's toggling output, and keeps BCD time of day 00:00–23:59.
- Holds a settable alarm time and drives the ringing output through a small alarm FSM.
- Outputs feed the display multiplexer and buzzer stages.

Parameters:
ALARM_DUR_MIN, 1, number of minute ticks the alarm rings before auto-stop (1–59)
AL_RST_HR, 6, alarm hour loaded at reset (0–23)

Ports:
reloje  in  1  system clock; only clock in the block
rst_n  in  1  synchronous active-low reset, sampled on posedge reloje
tick_in  in  1  divider output; each rising edge = one minute elapsed
modo  in  2  00 run, 01 set time, 10 set alarm, 11 treated as 00
inc_min  in  1  level from debounced button; rising edge = +1 minute on selected register
inc_hr  in  1  level from debounced button; rising edge = +1 hour on selected register
alarma_en  in  1  alarm armed when 1
apagar  in  1  level; 1 stops a ringing alarm
hr_d  out  2  time hours tens (BCD)
hr_u  out  4  time hours units (BCD)
min_d  out  3  time minutes tens (BCD)
min_u  out  4  time minutes units (BCD)
al_hr_d, al_hr_u, al_min_d, al_min_u  out  2/4/3/4  alarm time, same encoding
sonando  out  1  alarm ringing

Behaviour:
- Clocking: all state updates on posedge reloje only; no logic clocked by tick_in.
- Synchroniser: tick_in passes 2 flops (s1, s2) then s3. tick = s2 & ~s3.
- Latency: time changes on the 3rd reloje edge that samples tick_in high.
- inc_min and inc_hr: each gets a 2-flop synchroniser plus an edge detect, giving one-cycle pulses.
- Reset (rst_n=0 on an edge):
  - time = 00:00.
  - alarm = AL_RST_HR:00.
  - synchroniser flops = 0.
  - FSM = IDLE, ring counter = 0, sonando = 0.
  - Reset overrides every other input in the same cycle.
- Time counting when tick=1 and modo != 01:
  - min_u 9→0 carries to min_d; min_d 5→0 carries to hours.
  - Hours count 00→23, then 23:59→00:00.
- Set time (modo=01):
  - tick ignored; time frozen.
  - inc_min pulse: minutes +1, 59→00, no carry into hours.
  - inc_hr pulse: hours +1, 23→00.
  - inc_min and inc_hr in the same cycle: both apply.
- Set alarm (modo=10):
  - inc pulses edit the alarm registers with the same wrap rules.
  - Time keeps counting.
- Button pulses in modo 00/11 are ignored.
- All BCD digits always remain legal; no intermediate illegal values are ever output.
- match = (time == alarm), combinational on the registered values.
- FSM states:
  - IDLE: go to RING when alarma_en=1, modo != 01, match=1, and the time changed in the previous cycle (a tick or set edit brought time onto the alarm). Matching at reset or after disarm does not trigger.
  - RING: sonando=1; ring counter increments on each tick. Exits, in priority order:
    - rst_n=0 → IDLE
    - alarma_en=0 or modo=01 → IDLE
    - apagar=1 → DONE
    - ring counter reaches ALARM_DUR_MIN on a tick → DONE
  - DONE: sonando=0; go to IDLE when match=0, so there is no re-trigger within the same minute.
- sonando is registered: it rises 1 cycle after the time update that creates the match.
- Ring counter clears on entry to RING.
- apagar held across a trigger: RING is entered for one cycle, then DONE.
- Editing alarm to equal the current time does not trigger, because the trigger needs a time change.

Test Plan:
- Reset then 60 tick_in rising edges → 01:00. Check the 3-cycle latency on the first tick.
- Preload 23:59 via modo=01 (inc_hr×23, inc_min×59), modo=00, one tick → 00:00, no spurious digits.
- modo=01, inc_min from 00:59 → 00:00 with hours unchanged; inc_hr at 23 → 00. Ticks in set mode → no change.
- Alarm 06:00 armed, time 05:59, tick → sonando=1 next cycle. Then one further tick with ALARM_DUR_MIN=1 → sonando=0, state DONE until 06:01, no re-trigger.
- While ringing: apagar=1 → sonando=0 next cycle. Separate run: alarma_en=0 → IDLE. Separate run: rst_n=0 mid-ring → all outputs at reset values on the next edge.
- modo=10, edit alarm to the current time → no ring. Time continues counting during the edit; the next alarm match reached by a tick rings.
